// File: rtl/rasterizer_vertex_stream.sv
// Avalon-MM vertex fetcher: reads a triangle-count header, streams WORDS_PER_TRI words per
// triangle into a show-ahead record FIFO. Optional perf counters: define RAST_VF_PERF_EN.
module rasterizer_vertex_stream #(
  parameter int unsigned ADDR_W          = 26,
  parameter int unsigned WORDS_PER_TRI   = 15,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned MAX_TRI_W       = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic [ADDR_W-1:0]             master_address,
  output logic                          master_read,
  output logic                          master_write,
  output logic [3:0]                    master_byteenable,
  output logic [31:0]                   master_writedata,
  input  logic [31:0]                   master_readdata,
  input  logic                          master_readdatavalid,
  input  logic                          master_waitrequest,
  input  logic                          fetch_enable,
  input  logic [ADDR_W-1:0]             vertex_buffer_base,
  input  logic                          stall_in,
  output logic                          output_valid,
  output logic [32*WORDS_PER_TRI-1:0]   vertex_out,
  output logic                          done_out,
  output logic                          busy
`ifdef RAST_VF_PERF_EN
  ,
  output logic [31:0]                   perf_wait_cycles,
  output logic [31:0]                   perf_stall_cycles
`endif
);

  localparam int unsigned DEPTH = 2**FIFO_DEPTH_LOG2;
  localparam int unsigned REC_W = 32*WORDS_PER_TRI;
  localparam int unsigned WC_W  = (WORDS_PER_TRI > 1) ? $clog2(WORDS_PER_TRI) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_TRI-1);

  typedef enum logic [2:0] {IDLE, HDR, HDR_WAIT, REQ, DRAIN, DONE} state_t;
  state_t state;

  logic [ADDR_W-1:0]          base_q;
  logic [MAX_TRI_W-1:0]       tri_count, issued_tris, in_flight, delivered;
  logic [WC_W-1:0]            req_word, rx_word;
  logic [REC_W-1:0]           asm_buf;
  logic                       push_pending;
  logic [REC_W-1:0]           fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   fifo_count;
  logic [MAX_TRI_W:0]         credit_sum;
  logic                       pop, accept, rx_beat, credit_ok, issue_tri, start;

  assign master_write      = 1'b0;
  assign master_byteenable = '1;
  assign master_writedata  = '0;

  always_comb begin
    output_valid = (fifo_count != '0);
    vertex_out   = output_valid ? fifo_mem[rd_ptr] : '0;
    pop          = output_valid && !stall_in;
    accept       = master_read && !master_waitrequest;
    start        = (state == IDLE) && fetch_enable;
    // Beats outside an active data phase (e.g. stragglers after reset) are dropped.
    rx_beat      = master_readdatavalid && ((state == REQ) || (state == DRAIN)) && (in_flight != '0);
    // A triangle reserves its FIFO slot when its first read is issued.
    credit_sum   = (MAX_TRI_W+1)'(fifo_count) + {1'b0, in_flight};
    credit_ok    = credit_sum < (MAX_TRI_W+1)'(DEPTH);
    issue_tri    = (state == REQ) && !master_read && (issued_tris != tri_count) && credit_ok;
    busy         = (state != IDLE) && (state != DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      master_read    <= 1'b0;
      master_address <= '0;
      base_q         <= '0;
      tri_count      <= '0;
      issued_tris    <= '0;
      req_word       <= '0;
      done_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fetch_enable) begin
          base_q         <= vertex_buffer_base;
          master_address <= vertex_buffer_base;
          master_read    <= 1'b1;
          issued_tris    <= '0;
          req_word       <= '0;
          state          <= HDR;
        end
        HDR: if (!master_waitrequest) begin
          master_read <= 1'b0;
          state       <= HDR_WAIT;
        end
        HDR_WAIT: if (master_readdatavalid) begin
          tri_count <= MAX_TRI_W'(master_readdata);
          if (master_readdata == '0) begin
            done_out <= 1'b1;
            state    <= DONE;
          end else begin
            master_address <= base_q + ADDR_W'(4);
            state          <= REQ;
          end
        end
        REQ: begin
          if (accept) begin
            master_address <= master_address + ADDR_W'(4);
            if (req_word == LAST_WORD) begin
              req_word    <= '0;
              master_read <= 1'b0;
              if (issued_tris == tri_count) state <= DRAIN;
            end else begin
              req_word <= req_word + WC_W'(1);
            end
          end else if (issue_tri) begin
            master_read <= 1'b1;
            issued_tris <= issued_tris + MAX_TRI_W'(1);
          end
        end
        DRAIN: if (delivered == tri_count) begin
          done_out <= 1'b1;
          state    <= DONE;
        end
        DONE: if (!fetch_enable) begin
          done_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Record storage carries no reset; validity is tracked by the pointers and counters.
  always_ff @(posedge clock) begin
    if (rx_beat) asm_buf[32*rx_word +: 32] <= master_readdata;
    if (push_pending) fifo_mem[wr_ptr] <= asm_buf;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      push_pending <= 1'b0;
      rx_word      <= '0;
      in_flight    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      delivered    <= '0;
    end else begin
      push_pending <= 1'b0;
      if (rx_beat) begin
        if (rx_word == LAST_WORD) begin
          rx_word      <= '0;
          push_pending <= 1'b1;
        end else begin
          rx_word <= rx_word + WC_W'(1);
        end
      end
      in_flight <= in_flight + MAX_TRI_W'(issue_tri) - MAX_TRI_W'(push_pending);
      if (push_pending) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      case ({push_pending, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_DEPTH_LOG2+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_DEPTH_LOG2+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (start) delivered <= '0;
      else if (pop) delivered <= delivered + MAX_TRI_W'(1);
    end
  end

`ifdef RAST_VF_PERF_EN
  always_ff @(posedge clock) begin
    if (reset || start) begin
      perf_wait_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (master_read && master_waitrequest && (perf_wait_cycles != '1))
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
      if (output_valid && stall_in && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
